audio_fifo_player: RTL

- Downstream consumer of the audio sample FIFO that the Nios system fills through its audio2fifo exports (write data, wrreq, divfrec, pause, stop).
- Reads one 32-bit stereo word (L = [31:16], R = [15:0]) per sample period; the period is set by the processor-programmed divider.
- Presents registered L/R samples plus a one-cycle strobe to the codec/DAC serializer.
- Handles priming, pause, stop-with-flush and underflow accounting.

---
 rtl/audio_player_pkg.sv | 28 ++
 rtl/rate_tick_gen.sv | 31 +++
 rtl/audio_fifo_player.sv | 108 ++++++++++
 3 files changed

// File: rtl/audio_player_pkg.sv
// Shared types and constants for the audio FIFO playback path.
// Stereo words carry the left channel in the upper half and the right channel in the lower half.
package audio_player_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    PAUSED,
    DRAIN
  } state_t;

  localparam int DEFAULT_SAMPLE_W    = 16;
  localparam int DEFAULT_START_LEVEL = 256;

  // Channel slice bounds within a 2*sample_w stereo word.
  function automatic int l_msb(input int sample_w);
    return 2 * sample_w - 1;
  endfunction

  function automatic int l_lsb(input int sample_w);
    return sample_w;
  endfunction

  function automatic int r_msb(input int sample_w);
    return sample_w - 1;
  endfunction

endpackage

// File: rtl/rate_tick_gen.sv
// Sample-period divider: counts clk cycles while enabled and flags the last cycle of each period.
// The count freezes while disabled and is forced to zero by clear.
module rate_tick_gen #(
  parameter int DIV_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clear,
  input  logic [DIV_W-1:0] div_freq,
  output logic             tick
);

  logic [DIV_W-1:0] count;
  logic             period_end;

  // div_freq is compared live, so a new value shortens or extends the period in flight.
  always_comb begin
    if (div_freq <= DIV_W'(1)) period_end = 1'b1;
    else                       period_end = (count >= div_freq - DIV_W'(1));
  end

  assign tick = enable && period_end;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) count <= '0;
    else if (enable)       count <= period_end ? '0 : count + DIV_W'(1);
  end

endmodule

// File: rtl/audio_fifo_player.sv
// Drains a show-ahead stereo sample FIFO at a programmable rate, presenting registered L/R samples
// with a one-cycle strobe, plus priming, pause, stop-with-flush and underflow accounting.
module audio_fifo_player
  import audio_player_pkg::*;
#(
  parameter int DATA_W      = 2 * DEFAULT_SAMPLE_W,
  parameter int SAMPLE_W    = DEFAULT_SAMPLE_W,
  parameter int DIV_W       = 32,
  parameter int USED_W      = 12,
  parameter int START_LEVEL = DEFAULT_START_LEVEL,
  parameter int UFLOW_W     = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [DIV_W-1:0]    div_freq,
  input  logic                pause,
  input  logic                stop,
  input  logic [DATA_W-1:0]   fifo_q,
  input  logic                fifo_empty,
  input  logic [USED_W-1:0]   fifo_used,
  output logic                fifo_rdreq,
  output logic [SAMPLE_W-1:0] sample_l,
  output logic [SAMPLE_W-1:0] sample_r,
  output logic                sample_strobe,
  output logic [UFLOW_W-1:0]  underflow_cnt,
  output logic                playing
);

  localparam int L_MSB = l_msb(SAMPLE_W);
  localparam int L_LSB = l_lsb(SAMPLE_W);
  localparam int R_MSB = r_msb(SAMPLE_W);

  if (DATA_W != 2 * SAMPLE_W) begin : g_bad_width
    $error("audio_fifo_player: DATA_W must equal 2*SAMPLE_W");
  end

  state_t state, next_state;
  logic   tick;
  logic   strobe_pending;

  rate_tick_gen #(.DIV_W(DIV_W)) u_rate_tick_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (state == PLAY),
    .clear    (state == IDLE),
    .div_freq (div_freq),
    .tick     (tick)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    next_state     = state;
    strobe_pending = 1'b0;
    fifo_rdreq     = 1'b0;
    case (state)
      IDLE: begin
        if (!stop && fifo_used >= USED_W'(START_LEVEL)) next_state = PLAY;
      end
      PLAY: begin
        // stop and pause both swallow a coincident tick: no read, no strobe.
        strobe_pending = tick && !stop && !pause;
        fifo_rdreq     = strobe_pending && !fifo_empty;
        if (stop)       next_state = DRAIN;
        else if (pause) next_state = PAUSED;
      end
      PAUSED: begin
        if (stop)        next_state = DRAIN;
        else if (!pause) next_state = PLAY;
      end
      DRAIN: begin
        fifo_rdreq = !fifo_empty;
        if (fifo_empty && !stop) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (!reset_n) fifo_rdreq = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sample_l      <= '0;
      sample_r      <= '0;
      sample_strobe <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      sample_strobe <= strobe_pending;
      if (next_state == IDLE || next_state == DRAIN) begin
        sample_l <= '0;
        sample_r <= '0;
      end else if (strobe_pending && !fifo_empty) begin
        sample_l <= fifo_q[L_MSB:L_LSB];
        sample_r <= fifo_q[R_MSB:0];
      end
      if (state == IDLE && next_state == PLAY)
        underflow_cnt <= '0;
      else if (strobe_pending && fifo_empty && underflow_cnt != '1)
        underflow_cnt <= underflow_cnt + UFLOW_W'(1);
    end
  end

  assign playing = (state == PLAY);

endmodule
